// File: rtl/alu_share_arbiter_pkg.sv
// Purpose : shared ALU opcode encodings and response-slot state type.
// Latency : n/a (definitions only).
// Backpr. : n/a.
// Contents: ALU_* opcode localparams (also consumed by the instruction
//           decoder), rsp_state_e for the one-entry response register.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  // ALU control codes. Bit 3 selects the "alternate" flavour of an
  // operation (SUB vs ADD, SRA vs SRL), matching the decoder's funct7 bit.
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'b1001;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purpose : single-cycle 32-bit integer ALU with zero flag.
// Latency : purely combinational.
// Backpr. : none; caller registers the result.
// Ports   : a_i/b_i operands, op_i control code; result_o, zero_o.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      // LUI: the immediate is already positioned in b by the decoder.
      ALU_LUI:  result_o = b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Purpose : round-robin arbiter, searches from last_grant+1 with wrap.
// Latency : purely combinational.
// Backpr. : none; caller qualifies the grant with its own ready.
// Ports   : req_i request vector, last_grant_i pointer; grant_o one-hot,
//           grant_idx_o encoded winner, grant_vld_o any winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               grant_vld_o
);

  logic found;

  // Two passes: first the requesters above the pointer (lowest wins),
  // then wrap to those at or below it. Equivalent to a rotating search.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req_i[i] && (i > int'(last_grant_i))) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req_i[i] && (i <= int'(last_grant_i))) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = ID_W'(i);
      end
    end
    grant_vld_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one ALU among NUM_REQ requesters, round-robin.
// Latency : accept in cycle N -> response valid from cycle N+1.
// Backpr. : one-entry response slot; no grant while the owner stalls it,
//           same-cycle refill when the owner drains it.
// Ports   : req_valid/req_ready/req_a/req_b/req_op per requester (packed);
//           rsp_valid/rsp_ready per requester; rsp_result/rsp_zero/rsp_id
//           shared and registered.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic [ID_W-1:0]           rsp_id
);

  rsp_state_e        state_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   last_grant_q;

  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;

  logic               rsp_full;
  logic               owner_rdy;
  logic               can_accept;
  logic               accept;
  logic               drain;

  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [OP_W-1:0]    alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_vld_o  (grant_vld)
  );

  assign rsp_full  = (state_q == RSP_FULL);
  // Only the owner's ready can free the slot; other bits are ignored.
  assign owner_rdy = rsp_ready[id_q];
  assign drain     = rsp_full & owner_rdy;
  // Slot is free if empty or being drained this very cycle (pass-through).
  assign can_accept = !rsp_full | owner_rdy;
  assign accept     = grant_vld & can_accept;
  assign req_ready  = grant & {NUM_REQ{can_accept}};

  assign alu_a  = a_arr[grant_idx];
  assign alu_b  = b_arr[grant_idx];
  assign alu_op = op_arr[grant_idx];

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RSP_EMPTY;
      result_q     <= '0;
      zero_q       <= 1'b0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      // Payload and priority move only on an accept; a drain alone keeps
      // the last response visible (though no longer valid).
      if (accept) begin
        result_q     <= alu_result;
        zero_q       <= alu_zero;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
      case (state_q)
        RSP_EMPTY: if (accept)          state_q <= RSP_FULL;
        RSP_FULL:  if (drain && !accept) state_q <= RSP_EMPTY;
        default:                        state_q <= RSP_EMPTY;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_vld
    assign rsp_valid[g] = rsp_full & (id_q == ID_W'(g));
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic [ID_W-1:0]       rsp_id;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {id, zero, result}
  logic [33:0] sb_q[$];

  // Op-coverage table for requester 1
  logic [31:0] t_a   [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
  logic [31:0] t_b   [5] = '{32'd4,         32'd1,         32'd1,         32'h1234_5000, 32'h0000_0001};
  logic [3:0]  t_op  [5] = '{4'b1101,       4'b0010,       4'b0011,       4'b1001,       4'b1111};
  logic [31:0] t_res [5] = '{32'hF800_0000, 32'd1,         32'd0,         32'h1234_5000, 32'd0};
  logic        t_zero[5] = '{1'b0,          1'b0,          1'b1,          1'b0,          1'b1};

  alu_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = 32'($signed(a) >>> b[4:0]);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: r = b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Scoreboard: push on accept, pop and compare on owner drain.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if ((rsp_valid != '0) && rsp_ready[rsp_id]) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: response id=%0d result=%h with nothing expected", rsp_id, rsp_result);
        end else begin
          logic [33:0] exp;
          exp = sb_q.pop_front();
          if ({rsp_id, rsp_zero, rsp_result} !== exp ||
              rsp_valid !== (2'b01 << rsp_id)) begin
            failures++;
            $display("FAIL sb_response: got id=%0d zero=%0b result=%h valid=%b, expected id=%0d zero=%0b result=%h",
                     rsp_id, rsp_zero, rsp_result, rsp_valid, exp[33], exp[32], exp[31:0]);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          sb_q.push_back({1'(i), alu_model(req_a[i*32 +: 32], req_b[i*32 +: 32], req_op[i*4 +: 4])});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      failures++; $display("FAIL reset_rsp_regs: got result=%h zero=%b id=%0d want 0/0/0", rsp_result, rsp_zero, rsp_id);
    end
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd7, 4'b0000);
    req_valid = 2'b01; rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got valid=%b result=%0d zero=%b id=%0d want 01/12/0/0", rsp_valid, rsp_result, rsp_zero, rsp_id);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, prev_g;
    // Requester 0 was granted last, so requester 1 leads.
    exp_g = 2'b10; prev_g = 2'b00;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      set_req(0, 32'(c * 3), 32'd1, 4'b0000);
      set_req(1, 32'h0000_00F0 + 32'(c), 32'(c), 4'b0100);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g) begin failures++; $display("FAIL contention_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
      if (c > 0) begin
        checks++;
        if (rsp_valid !== prev_g) begin failures++; $display("FAIL contention_rsp c=%0d: got %b want %b", c, rsp_valid, prev_g); end
      end
      prev_g = exp_g;
      exp_g  = {exp_g[0], exp_g[1]};
      next_cycle();
    end
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== prev_g) begin failures++; $display("FAIL contention_tail: got %b want %b", rsp_valid, prev_g); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    set_req(1, 32'd9, 32'd9, 4'b1000);
    req_valid = 2'b10; rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_accept: got %b want 10", req_ready); end
    next_cycle();
    set_req(0, 32'd3, 32'd4, 4'b0000);
    req_valid = 2'b01; rsp_ready = 2'b01;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_stall_ready s=%0d: got %b want 00", s, req_ready); end
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall_hold s=%0d: got valid=%b result=%h zero=%b want 10/0/1", s, rsp_valid, rsp_result, rsp_zero);
      end
      next_cycle();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_passthrough: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd7) begin
      failures++; $display("FAIL bp_after: got valid=%b result=%0d want 01/7", rsp_valid, rsp_result);
    end
    next_cycle();
  endtask

  task automatic test_non_owner();
    set_req(0, 32'h0F0F_0000, 32'h0000_00FF, 4'b0110);
    req_valid = 2'b01; rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL nonowner_accept: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00; rsp_ready = 2'b10;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01) begin failures++; $display("FAIL nonowner_hold s=%0d: got %b want 01", s, rsp_valid); end
      next_cycle();
    end
    rsp_ready = 2'b11;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL nonowner_drained: got %b want 00", rsp_valid); end
    next_cycle();
  endtask

  task automatic test_ops();
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        set_req(1, t_a[k], t_b[k], t_op[k]);
        req_valid = 2'b10;
      end else begin
        req_valid = 2'b00;
      end
      @(negedge clk);
      if (k < 5) begin
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL ops_grant k=%0d: got %b want 10", k, req_ready); end
      end
      if (k > 0) begin
        checks++;
        if (rsp_result !== t_res[k-1] || rsp_zero !== t_zero[k-1] || rsp_id !== 1'b1) begin
          failures++;
          $display("FAIL ops_result k=%0d: got result=%h zero=%b id=%0d want %h/%b/1",
                   k - 1, rsp_result, rsp_zero, rsp_id, t_res[k-1], t_zero[k-1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd2, 32'd2, 4'b0000);
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL arst_fill: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_id !== 1'b0) begin
      failures++; $display("FAIL arst_clear: got valid=%b result=%h id=%0d want 00/0/0", rsp_valid, rsp_result, rsp_id);
    end
    next_cycle();
    rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL arst_priority: got %b want 01", req_ready); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b01 || rsp_result !== 32'd2) begin
      failures++; $display("FAIL arst_second: got ready=%b valid=%b result=%0d want 10/01/2", req_ready, rsp_valid, rsp_result);
    end
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_non_owner();
    test_ops();
    test_async_reset();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover: %0d responses never returned, want 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU among NUM_REQ requesters, e.g. the cores' auxiliary address/compare units.
- Requests are arbitrated round-robin through a valid/ready handshake and computed in one cycle.
- Each result is held in a one-entry response register that carries the owner ID. The response is returned on that owner's response channel, also valid/ready.
- Sits between the core-side request ports and one instance of the team's alu block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, owner-ID width; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted this cycle.
- req_a  in  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- req_op  in  NUM_REQ*4  ALU control code (alu_ctrl encoding), 4 bits per requester.
- rsp_valid  out  NUM_REQ  per-requester response valid.
- rsp_ready  in  NUM_REQ  per-requester response consumed.
- rsp_result  out  32  registered ALU result, shared by all requesters.
- rsp_zero  out  1  registered zero flag, shared by all requesters.
- rsp_id  out  ID_W  owner of the current response.

Behaviour:
- Reset, asynchronous on rst_n low:
  - rsp_full=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Response-register states: EMPTY (rsp_full=0) and FULL (rsp_full=1).
- can_accept = !rsp_full | rsp_ready[rsp_id]. Pass-through is allowed: a slot drained this cycle may be refilled in the same cycle.
- Grant, combinational: first i with req_valid[i], searching from last_grant+1 with wrap-around mod NUM_REQ.
  - req_ready[i] = grant[i] & can_accept.
  - At most one req_ready bit is high per cycle.
  - req_ready never depends on req_ready itself. It may depend on req_valid and rsp_ready.
- Accept edge (any req_ready high):
  - rsp_result <= alu(a_i, b_i, op_i).result; rsp_zero <= alu zero; rsp_id <= i.
  - rsp_full <= 1; last_grant <= i.
- Drain without accept: rsp_full <= 0. rsp_result, rsp_zero and rsp_id hold their values.
- Latency: accept on cycle N gives rsp_valid[i] high from cycle N+1. Throughput is 1 op/cycle when owners consume immediately.
- rsp_valid[i] = rsp_full & (rsp_id==i). The response stays stable until rsp_ready[rsp_id] is sampled high.
- rsp_ready of a non-owner is ignored.
- No grant while FULL and the owner stalls. Pending requesters keep req_valid high and their operands stable; this is the requester's contract.
- Arithmetic is the ALU's own: 32-bit wrap, shift amount b[4:0]. An unknown op returns 0 with rsp_zero=1.
- last_grant updates only on an accept. An idle cycle does not move priority.
- A single active requester is granted every cycle it is eligible.
- Reset mid-operation: a pending response is discarded, and requesters re-issue.

Decomposition:
- Shared package/header (alu_defs):
  - ALU op localparams: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, LUI=1001.
  - Also used by the decoder.
- Sub-module rr_arbiter (NUM_REQ): req vector + last_grant in, one-hot grant + encoded index out. Purely combinational, reusable for other shared resources.
- ALU instantiated once inside, fed by a mux on the encoded grant index.

Test Plan:
- Single op, NUM_REQ=2: req0 ADD a=5, b=7, rsp_ready=1 -> req_ready[0] same cycle; next cycle rsp_valid=01, rsp_result=12, rsp_zero=0, rsp_id=0.
- Contention: req0 and req1 valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1. Responses 1 cycle behind, each tagged with its rsp_id, one per cycle, no bubbles.
- Back-pressure: req1 SUB 9-9 accepted, rsp_ready[1]=0 for 3 cycles while req0 is valid -> req_ready=00 during the stall. rsp_result=0 with rsp_zero=1 held stable. req0 is granted in the cycle rsp_ready[1] rises (pass-through).
- Non-owner ready: response owned by 0, rsp_ready=10 -> response not drained, rsp_valid stays 01.
- Op coverage: requester 1 runs SRA 0x80000000>>4 -> 0xF8000000, SLT -1<1 -> 1, SLTU -1<1 -> 0, LUI b=0x12345000 -> 0x12345000, op 1111 -> 0 with zero=1.
- Async reset: assert rst_n=0 mid-cycle while FULL -> all rsp_valid low immediately, rsp_result=0. After release, requester 0 wins first over simultaneous req1.
